// File: rtl/apb_master_bridge_pkg.sv
// apb_bridge_pkg: shared types and helpers for the APB requester bridge.
//   state_e - bridge FSM states
//   err_e   - cause of a completed transfer's status
//   sel_w   - width of a select index for n items, never below 1
package apb_bridge_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
    typedef enum logic [1:0] {OK, SLV, DEC, TMO} err_e;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: APB4 bus between the requester bridge and NUM_SLV slaves.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB  requester -> slaves
//   PRDATA (slave i at [i*DATA_W +: DATA_W]), PREADY, PSLVERR_IN  slaves -> requester
interface apb_master_bridge_if #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2
);
    localparam int STRB_W = DATA_W / 8;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [STRB_W-1:0]         PSTRB;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR_IN;
    modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                   input PRDATA, PREADY, PSLVERR_IN);
    modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  output PRDATA, PREADY, PSLVERR_IN);
endinterface

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps the top address bits onto a one-hot slave select.
//   addr    in   captured APB address
//   onehot  out  one-hot select, all-0 when no slave owns the address
//   sel     out  slave index taken from the top SEL_W address bits
//   dec_err out  address selects a slave index that does not exist
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int NUM_SLV = 2,
    localparam int SEL_W  = sel_w(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] onehot,
    output logic [SEL_W-1:0]   sel,
    output logic               dec_err
);
    assign sel = addr[ADDR_W-1 -: SEL_W];
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) onehot[i] = sel == SEL_W'(i);
    end
    assign dec_err = ~|onehot;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB4 requester turning transfer/READ_WRITE requests into SETUP/ACCESS cycles.
//   PCLK, PRESETn           clock, asynchronous active-low reset
//   transfer, READ_WRITE    request valid and direction (1 = write)
//   apb_write_paddr/_data/_strb, apb_read_paddr   request payload
//   apb_read_data_out       data of the last error-free read
//   PSLVERR, xfer_done      status of the last transfer and its completion pulse
//   busy                    high in SETUP and ACCESS
//   apb                     APB bus towards the slaves
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int NUM_SLV     = 2,
    parameter int TIMEOUT_CYC = 16,
    localparam int STRB_W     = DATA_W / 8,
    localparam int SEL_W      = sel_w(NUM_SLV),
    localparam int CNT_W      = sel_w(TIMEOUT_CYC + 1)
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                transfer,
    input  logic                READ_WRITE,
    input  logic [ADDR_W-1:0]   apb_write_paddr,
    input  logic [DATA_W-1:0]   apb_write_data,
    input  logic [STRB_W-1:0]   apb_write_strb,
    input  logic [ADDR_W-1:0]   apb_read_paddr,
    output logic [DATA_W-1:0]   apb_read_data_out,
    output logic                PSLVERR,
    output logic                xfer_done,
    output logic                busy,
    apb_master_bridge_if.master apb
);
    state_e             state, state_nxt;
    err_e               cause;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SLV-1:0] onehot;
    logic [SEL_W-1:0]   sel;
    logic               dec_err, ready, slv_err, tmo, done;

    apb_addr_decoder #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
        .addr(apb.PADDR), .onehot(onehot), .sel(sel), .dec_err(dec_err)
    );

    // Masking with the one-hot select ignores every non-selected slave.
    assign ready   = |(apb.PREADY & onehot);
    assign slv_err = |(apb.PSLVERR_IN & onehot);
    // Abort on the ACCESS cycle that would make the stall count reach TIMEOUT_CYC.
    assign tmo     = (TIMEOUT_CYC != 0) && !ready && !dec_err && cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign done    = state == ACCESS && (ready || dec_err || tmo);
    assign cause   = dec_err ? DEC : !ready ? TMO : slv_err ? SLV : OK;

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt   = state;
        busy        = state != IDLE;
        apb.PENABLE = state == ACCESS;
        apb.PSEL    = busy ? onehot : '0;
        if (state == IDLE)       state_nxt = transfer ? SETUP : IDLE;
        else if (state == SETUP) state_nxt = ACCESS;
        else if (done)           state_nxt = (transfer && cause != TMO) ? SETUP : IDLE;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt               <= '0;
            xfer_done         <= 1'b0;
            PSLVERR           <= 1'b0;
            apb_read_data_out <= '0;
            apb.PWRITE        <= 1'b0;
            apb.PADDR         <= '0;
            apb.PWDATA        <= '0;
            apb.PSTRB         <= '0;
        end else begin
            cnt       <= (state == ACCESS && !done) ? cnt + 1'b1 : '0;
            xfer_done <= done;
            // Capture only on entry to SETUP, so the bus stays stable through ACCESS.
            if (state_nxt == SETUP) begin
                apb.PWRITE <= READ_WRITE;
                apb.PADDR  <= READ_WRITE ? apb_write_paddr : apb_read_paddr;
                apb.PWDATA <= apb_write_data;
                apb.PSTRB  <= READ_WRITE ? apb_write_strb : '0;
            end
            if (done) PSLVERR <= cause != OK;
            if (done && cause == OK && !apb.PWRITE)
                apb_read_data_out <= apb.PRDATA[int'(sel) * DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: self-checking bench for apb_master_bridge (3 slaves, 16-bit data, timeout 4).
module tb_apb_master_bridge;
    localparam int AW = 9, DW = 16, NS = 3, TMO = 4;

    typedef struct {
        bit          rw;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] prdata;
        logic [1:0]  strb;
        int          waits;
        bit          err;
        int          lat;
        bit          perr;
        logic [15:0] rd;
    } vec_t;

    logic        PCLK, PRESETn, transfer, READ_WRITE;
    logic [8:0]  apb_write_paddr, apb_read_paddr;
    logic [15:0] apb_write_data, apb_read_data_out;
    logic [1:0]  apb_write_strb;
    logic        PSLVERR, xfer_done, busy;
    int          tests, fails;
    logic [15:0] rd_model;
    vec_t        tbl[10];
    vec_t        v;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT_CYC(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_write_strb(apb_write_strb), .apb_read_paddr(apb_read_paddr),
        .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR), .xfer_done(xfer_done),
        .busy(busy), .apb(bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Transaction-level reference: slave index from the top address bits, ACCESS length
    // from wait-states capped by the timeout, status and read-data update from the outcome.
    function automatic vec_t model(input vec_t x, input logic [15:0] prev);
        int  sel;
        bit  dec, tmo;
        sel    = int'(x.addr[8:7]);
        dec    = sel >= NS;
        tmo    = !dec && x.waits >= TMO;
        x.lat  = 2 + (dec ? 1 : tmo ? TMO : x.waits + 1);
        x.perr = dec || tmo || x.err;
        x.rd   = (!x.rw && !x.perr) ? x.prdata : prev;
        return x;
    endfunction

    // Target slave answers after x.waits stalled ACCESS cycles; all other slaves are noise.
    task automatic drive_slaves(input vec_t x, input int cyc);
        int sel;
        sel = int'(x.addr[8:7]);
        for (int i = 0; i < NS; i++) begin
            bus.PRDATA[i*DW +: DW] = (i == sel) ? x.prdata : 16'($urandom);
            bus.PSLVERR_IN[i]      = (i == sel) ? x.err : 1'($urandom);
            bus.PREADY[i]          = (i == sel && cyc >= 2) ? (cyc - 1 > x.waits) : 1'($urandom);
        end
    endtask

    task automatic run(input vec_t x);
        int         sel, cyc;
        logic [2:0] psel_e;
        sel    = int'(x.addr[8:7]);
        psel_e = (sel < NS) ? 3'(1 << sel) : 3'b000;
        transfer        = 1'b1;
        READ_WRITE      = x.rw;
        apb_write_paddr = x.rw ? x.addr : 9'($urandom);
        apb_read_paddr  = x.rw ? 9'($urandom) : x.addr;
        apb_write_data  = x.wdata;
        apb_write_strb  = x.strb;
        drive_slaves(x, 0);
        for (cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc == 1) begin
                transfer        = 1'b0;
                READ_WRITE      = 1'($urandom);
                apb_write_paddr = 9'($urandom);
                apb_read_paddr  = 9'($urandom);
                apb_write_data  = 16'($urandom);
                apb_write_strb  = 2'($urandom);
            end
            if (xfer_done) break;
            check("bus", {busy, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
                  {1'b1, psel_e, cyc >= 2, x.rw, x.addr, x.wdata, x.rw ? x.strb : 2'b00});
            drive_slaves(x, cyc);
        end
        check("latency", 64'(cyc), 64'(x.lat));
        check("pslverr", PSLVERR, x.perr);
        check("rdata", apb_read_data_out, x.rd);
        check("idle", {busy, bus.PSEL, bus.PENABLE}, 0);
    endtask

    initial begin
        tests = 0; fails = 0; rd_model = '0;
        PRESETn = 1'b0; transfer = 1'b0; READ_WRITE = 1'b0;
        apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0; apb_write_strb = '0;
        bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR_IN = '0;
        //           rw    addr     wdata     prdata    strb  w  err  lat perr rd
        tbl[0] = '{1'b1, 9'h0A5, 16'h003C, 16'h1111, 2'b01, 0, 1'b0, 3, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 9'h105, 16'h0000, 16'h005A, 2'b11, 3, 1'b0, 6, 1'b0, 16'h005A};
        tbl[2] = '{1'b0, 9'h1C0, 16'h0000, 16'h7777, 2'b00, 0, 1'b0, 3, 1'b1, 16'h005A};
        tbl[3] = '{1'b0, 9'h040, 16'h0000, 16'h2222, 2'b00, 4, 1'b0, 6, 1'b1, 16'h005A};
        tbl[4] = '{1'b0, 9'h07F, 16'h0000, 16'hBEEF, 2'b00, 3, 1'b0, 6, 1'b0, 16'hBEEF};
        tbl[5] = '{1'b1, 9'h1FF, 16'h1234, 16'h3333, 2'b11, 0, 1'b0, 3, 1'b1, 16'hBEEF};
        tbl[6] = '{1'b0, 9'h0C3, 16'h0000, 16'h1234, 2'b00, 1, 1'b1, 4, 1'b1, 16'hBEEF};
        tbl[7] = '{1'b1, 9'h17E, 16'hA5A5, 16'h4444, 2'b10, 2, 1'b1, 5, 1'b1, 16'hBEEF};
        tbl[8] = '{1'b0, 9'h000, 16'h0000, 16'hC0DE, 2'b00, 0, 1'b0, 3, 1'b0, 16'hC0DE};
        tbl[9] = '{1'b1, 9'h0FF, 16'h9999, 16'h5555, 2'b01, 5, 1'b0, 6, 1'b1, 16'hC0DE};

        tick(); tick();
        check("reset_outputs", {busy, xfer_done, PSLVERR, apb_read_data_out, bus.PSEL, bus.PENABLE,
              bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB}, 0);
        PRESETn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run(tbl[i]);
            rd_model = tbl[i].rd;
        end

        // Back-to-back: write to slave 0, then a read to slave 1 captured in the completion cycle.
        transfer = 1'b1; READ_WRITE = 1'b1;
        apb_write_paddr = 9'h011; apb_write_data = 16'h7E81; apb_write_strb = 2'b11;
        apb_read_paddr = 9'h0C0;
        bus.PREADY = 3'b001; bus.PSLVERR_IN = 3'b000;
        tick();
        check("b2b_setup1", {busy, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}, {1'b1, 3'b001, 1'b0, 1'b1, 9'h011});
        READ_WRITE = 1'b0;
        tick();
        check("b2b_access1", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
              {3'b001, 1'b1, 1'b1, 9'h011, 16'h7E81, 2'b11});
        bus.PREADY = 3'b011; bus.PSLVERR_IN = 3'b010;
        tick();
        check("b2b_done1", {xfer_done, PSLVERR}, 2'b10);
        check("b2b_setup2", {busy, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PSTRB},
              {1'b1, 3'b010, 1'b0, 1'b0, 9'h0C0, 2'b00});
        transfer = 1'b0; bus.PRDATA[DW +: DW] = 16'hDEAD;
        tick();
        check("b2b_access2", {xfer_done, bus.PSEL, bus.PENABLE}, {1'b0, 3'b010, 1'b1});
        tick();
        check("b2b_done2", {xfer_done, PSLVERR, busy, bus.PSEL}, {1'b1, 1'b1, 1'b0, 3'b000});
        check("b2b_rdata_hold", apb_read_data_out, rd_model);

        // Timeout with the request held high must still return to IDLE.
        transfer = 1'b1; READ_WRITE = 1'b0; apb_read_paddr = 9'h040;
        bus.PREADY = 3'b000; bus.PSLVERR_IN = 3'b000;
        for (int i = 0; i < 5; i++) tick();
        check("tmo_last_access", {xfer_done, busy, bus.PENABLE}, 3'b011);
        tick();
        check("tmo_abort", {xfer_done, PSLVERR, busy, bus.PSEL, bus.PENABLE}, {1'b1, 1'b1, 1'b0, 3'b000, 1'b0});
        check("tmo_rdata_hold", apb_read_data_out, rd_model);
        transfer = 1'b0;
        tick();

        for (int n = 0; n < 40; n++) begin
            v.rw = 1'($urandom); v.addr = 9'($urandom); v.wdata = 16'($urandom);
            v.prdata = 16'($urandom); v.strb = 2'($urandom);
            v.waits = int'($urandom_range(0, 6)); v.err = 1'($urandom);
            v = model(v, rd_model);
            run(v);
            rd_model = v.rd;
        end

        // Reset in the middle of ACCESS drops the transfer and clears every output.
        v = model('{1'b0, 9'h002, 16'h0000, 16'h5A5A, 2'b00, 0, 1'b0, 0, 1'b0, 16'h0000}, rd_model);
        run(v);
        transfer = 1'b1; READ_WRITE = 1'b0; apb_read_paddr = 9'h0C1; bus.PREADY = 3'b000;
        tick(); tick();
        check("pre_reset_access", {busy, bus.PENABLE}, 2'b11);
        PRESETn = 1'b0;
        tick();
        check("mid_reset", {busy, xfer_done, PSLVERR, apb_read_data_out, bus.PSEL, bus.PENABLE,
              bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB}, 0);
        transfer = 1'b0; PRESETn = 1'b1; rd_model = '0;
        tick();
        v = model('{1'b0, 9'h101, 16'h0000, 16'h0F0F, 2'b00, 1, 1'b0, 0, 1'b0, 16'h0000}, rd_model);
        run(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
